icb_dma_master: RTL

- Word-granular memory-to-memory copy engine on the system peripheral bus.
- Its slave side is a standard sysp register slot, using the same waddr/data/sel/we/raddr/rd/data_o peripheral interface.
- Its master side is an ICB initiator. It issues read and write commands into the SoC interconnect.
- It is the initiator counterpart to the sysp ICB responder.
- One transaction is outstanding at a time. It raises an interrupt on completion.

---
 rtl/icb_dma_master.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/icb_dma_master.sv
// ---------------------------------------------------------------------------
// icb_dma_master
//
// Word-granular memory-to-memory copy engine. Software programs SRC, DST and
// LEN through a sysp register slot and sets START. The engine then copies LEN
// words, one ICB transaction outstanding at a time:
//   read word at src_ptr -> buffer -> write buffer to dst_ptr
// and raises DONE (and irq_o when IEN is set) at the end.
//
// Handshake semantics (both ICB channels): a beat transfers on a rising clk
// edge where valid && ready are both high. While cmd_valid is high, every cmd
// field is held stable until that edge. cmd_valid never depends on cmd_ready,
// and rsp_ready is high only while the engine waits for a response.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   waddr_i/data_i/sel_i/we_i   register write (byte enables per byte)
//   raddr_i/rd_i/data_o         register read, data_o registered on rd_i
//   irq_o              DONE & IEN
//   m_icb_cmd_*        ICB command channel (initiator)
//   m_icb_rsp_*        ICB response channel (initiator)
//
// Register map (word offsets, bits [1:0] of the address ignored)
//   0x00 CTRL  bit0 START(W1, reads 0) bit1 BUSY(RO) bit2 DONE(W1C)
//              bit3 ERR(W1C) bit4 IEN(RW)
//   0x04 SRC   0x08 DST   0x0C LEN (LEN_W bits)   0x10 CNT (RO)
//
// LEN_W must be below 32.
// ---------------------------------------------------------------------------
module icb_dma_master #(
    parameter int unsigned WR_RSP = 1,
    parameter int unsigned LEN_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    output logic [31:0] m_icb_cmd_addr,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready,
    input  logic        m_icb_rsp_err,
    input  logic [31:0] m_icb_rsp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_CMD = 3'd1,
        S_RD_RSP = 3'd2,
        S_WR_CMD = 3'd3,
        S_WR_RSP = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      src_q, dst_q;
    logic [31:0]      src_ptr_q, dst_ptr_q;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic             done_q, err_q, ien_q;
    logic             busy;

    // FSM strobes
    logic start_req;   // software wrote START=1 to CTRL
    logic load;        // start with LEN != 0: latch pointers and count
    logic zero_done;   // start with LEN == 0: finish without bus traffic
    logic abort;       // error response
    logic cap_buf;     // read data accepted
    logic word_done;   // write for the current word finished
    logic last_word;   // word_done on the final word

    // Register write decode
    logic [5:0]  widx, ridx;
    logic        wr_ctrl, wr_src, wr_dst, wr_len;
    logic [31:0] len_merge;
    logic [31:0] rd_mux;

    assign busy = (state_q != S_IDLE);
    assign widx = waddr_i[7:2];
    assign ridx = raddr_i[7:2];

    // SRC/DST/LEN are frozen while a transfer runs.
    assign wr_ctrl = we_i && (widx == 6'd0);
    assign wr_src  = we_i && (widx == 6'd1) && !busy;
    assign wr_dst  = we_i && (widx == 6'd2) && !busy;
    assign wr_len  = we_i && (widx == 6'd3) && !busy;

    assign start_req = wr_ctrl && sel_i[0] && data_i[0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    assign len_merge = merge_bytes(32'(len_q), data_i, sel_i);

    // Address bits [1:0] are don't-care; upper merged LEN bits are dropped.
    logic unused_ok;
    assign unused_ok = ^{waddr_i[1:0], raddr_i[1:0], len_merge[31:LEN_W]};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        load            = 1'b0;
        zero_done       = 1'b0;
        abort           = 1'b0;
        cap_buf         = 1'b0;
        word_done       = 1'b0;
        m_icb_cmd_valid = 1'b0;
        m_icb_cmd_read  = 1'b0;
        m_icb_cmd_addr  = 32'h0;
        m_icb_cmd_wdata = 32'h0;
        m_icb_cmd_wmask = 4'h0;
        m_icb_rsp_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (len_q != '0) begin
                        load    = 1'b1;
                        state_d = S_RD_CMD;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            S_RD_CMD: begin
                m_icb_cmd_valid = 1'b1;
                m_icb_cmd_read  = 1'b1;
                m_icb_cmd_addr  = {src_ptr_q[31:2], 2'b00};
                if (m_icb_cmd_ready) state_d = S_RD_RSP;
            end
            S_RD_RSP: begin
                m_icb_rsp_ready = 1'b1;
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cap_buf = 1'b1;
                        state_d = S_WR_CMD;
                    end
                end
            end
            S_WR_CMD: begin
                m_icb_cmd_valid = 1'b1;
                m_icb_cmd_addr  = {dst_ptr_q[31:2], 2'b00};
                m_icb_cmd_wdata = buf_q;
                m_icb_cmd_wmask = 4'hF;
                if (m_icb_cmd_ready) begin
                    // Without write responses the word retires on the cmd beat.
                    if (WR_RSP != 0) state_d = S_WR_RSP;
                    else             word_done = 1'b1;
                end
            end
            S_WR_RSP: begin
                m_icb_rsp_ready = 1'b1;
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        word_done = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (word_done) begin
            state_d = (cnt_q == LEN_W'(1)) ? S_IDLE : S_RD_CMD;
        end
    end

    assign last_word = word_done && (cnt_q == LEN_W'(1));

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= 32'h0;
            dst_q     <= 32'h0;
            len_q     <= '0;
            cnt_q     <= '0;
            src_ptr_q <= 32'h0;
            dst_ptr_q <= 32'h0;
            buf_q     <= 32'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ien_q     <= 1'b0;
            data_o    <= 32'h0;
        end else begin
            if (wr_src) src_q <= merge_bytes(src_q, data_i, sel_i);
            if (wr_dst) dst_q <= merge_bytes(dst_q, data_i, sel_i);
            if (wr_len) len_q <= len_merge[LEN_W-1:0];

            if (wr_ctrl && sel_i[0]) ien_q <= data_i[4];

            // Hardware set beats a same-cycle software clear.
            if (zero_done || abort || last_word) begin
                done_q <= 1'b1;
            end else if (wr_ctrl && sel_i[0] && data_i[2]) begin
                done_q <= 1'b0;
            end

            if (abort) begin
                err_q <= 1'b1;
            end else if (wr_ctrl && sel_i[0] && data_i[3]) begin
                err_q <= 1'b0;
            end

            if (load) begin
                src_ptr_q <= src_q;
                dst_ptr_q <= dst_q;
                cnt_q     <= len_q;
            end else if (word_done) begin
                src_ptr_q <= src_ptr_q + 32'd4;
                dst_ptr_q <= dst_ptr_q + 32'd4;
                cnt_q     <= cnt_q - LEN_W'(1);
            end

            if (cap_buf) buf_q <= m_icb_rsp_rdata;

            if (rd_i) data_o <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (ridx)
            6'd0:    rd_mux = {27'd0, ien_q, err_q, done_q, busy, 1'b0};
            6'd1:    rd_mux = src_q;
            6'd2:    rd_mux = dst_q;
            6'd3:    rd_mux = 32'(len_q);
            6'd4:    rd_mux = 32'(cnt_q);
            default: rd_mux = 32'h0;
        endcase
    end

    assign irq_o = done_q & ien_q;

endmodule
